// File: rtl/gate_selftest_ctrl_pkg.sv
// Shared types and golden model for the logic-gate self-test slice.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package gate_pkg;

    localparam int NUM_GATES = 7;

    // Bit positions of each gate output within the 7-bit result vector
    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    // Reference behaviour of the gate block; NOT acts on operand a
    function automatic logic [NUM_GATES-1:0] gate_expected(input logic a, input logic b);
        logic [NUM_GATES-1:0] r;
        r            = '0;
        r[GATE_AND]  = a & b;
        r[GATE_OR]   = a | b;
        r[GATE_NOT]  = ~a;
        r[GATE_NAND] = ~(a & b);
        r[GATE_NOR]  = ~(a | b);
        r[GATE_XOR]  = a ^ b;
        r[GATE_XNOR] = ~(a ^ b);
        return r;
    endfunction

endpackage

// File: rtl/gate_selftest_ctrl_if.sv
// Bundle of the run-control, operand and result signals of the self-test sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request, done/busy report status.
interface gate_selftest_ctrl_if #(
    parameter int CNT_W = 8
);
    import gate_pkg::*;

    logic                 start;
    logic                 op_a;
    logic                 op_b;
    logic [NUM_GATES-1:0] gate_res;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     err_cnt;
    logic                 fail_valid;
    logic [1:0]           fail_vec;
    logic [NUM_GATES-1:0] fail_mask;

    // Host side: requests runs, feeds back the gate outputs, reads results
    modport master (
        output start, gate_res,
        input  op_a, op_b, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_mask
    );

    // Sequencer side
    modport slave (
        input  start, gate_res,
        output op_a, op_b, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_mask
    );

endinterface

// File: rtl/gate_selftest_ctrl_golden.sv
// Combinational golden gate model wrapped as a module for reuse.
// Latency: 0 cycles.
// Backpressure: none.
module gate_golden
    import gate_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] res
);

    assign res = gate_expected(a, b);

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer: sweeps {a,b} through 00..11 PASSES times, compares gate outputs to golden.
// Latency: done rises 4*PASSES*(SETTLE_CYCLES+2) cycles after the edge that accepts start.
// Backpressure: none; start is ignored while busy, results held until next start or rst.
module gate_selftest_ctrl
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    gate_selftest_ctrl_if.slave bus
);

    localparam int SCNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PIDX_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [SCNT_W-1:0] SETTLE_LD = SCNT_W'(SETTLE_CYCLES);
    localparam logic [SCNT_W-1:0] SETTLE_ONE = SCNT_W'(1);
    localparam logic [PIDX_W-1:0] PASS_LAST = PIDX_W'(PASSES - 1);
    localparam logic [CNT_W-1:0]  ERR_MAX   = {CNT_W{1'b1}};

    state_e               state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [PIDX_W-1:0]    pass_idx_q, pass_idx_d;
    logic [SCNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic                 op_a_q, op_a_d;
    logic                 op_b_q, op_b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 fail_valid_q, fail_valid_d;
    logic [1:0]           fail_vec_q, fail_vec_d;
    logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;

    logic [NUM_GATES-1:0] golden_res;
    logic [NUM_GATES-1:0] mism;

    // Expected outputs follow the registered operands actually driven to the gate block
    gate_golden u_golden (
        .a   (op_a_q),
        .b   (op_b_q),
        .res (golden_res)
    );

    assign mism = bus.gate_res ^ golden_res;

    // State and datapath registers; reset drops any run in progress and all results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            pass_idx_q   <= '0;
            settle_cnt_q <= '0;
            op_a_q       <= 1'b0;
            op_b_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_mask_q  <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            pass_idx_q   <= pass_idx_d;
            settle_cnt_q <= settle_cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_mask_q  <= fail_mask_d;
        end
    end

    // Next-state: one APPLY, optional settle window, one CHECK per vector
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = APPLY;
            APPLY:   state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            SETTLE:  if (settle_cnt_q == SETTLE_ONE) state_d = CHECK;
            CHECK: begin
                if (vec_q == 2'd3 && pass_idx_q == PASS_LAST) state_d = IDLE;
                else                                           state_d = APPLY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand drive, settle countdown, mismatch scoring and run completion
    always_comb begin
        vec_d        = vec_q;
        pass_idx_d   = pass_idx_q;
        settle_cnt_d = settle_cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_mask_d  = fail_mask_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_cnt_d    = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    fail_mask_d  = '0;
                    vec_d        = '0;
                    pass_idx_d   = '0;
                    busy_d       = 1'b1;
                end
            end
            APPLY: begin
                op_a_d       = vec_q[1];
                op_b_d       = vec_q[0];
                settle_cnt_d = SETTLE_LD;
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q - SETTLE_ONE;
            end
            CHECK: begin
                // One failing vector counts once, however many gates disagree
                if (mism != '0) begin
                    if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                        fail_mask_d  = mism;
                    end
                end
                if (vec_q != 2'd3) begin
                    vec_d = vec_q + 2'd1;
                end else if (pass_idx_q != PASS_LAST) begin
                    vec_d      = '0;
                    pass_idx_d = pass_idx_q + PIDX_W'(1);
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_cnt_d == '0);
                end
            end
            default: ;
        endcase
    end

    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;
    assign bus.fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: three configurations, fault-injected gate models, result scoreboard.
// Latency: checks done arrives 4*PASSES*(SETTLE_CYCLES+2) cycles after busy rises.
// Backpressure: none; start is driven as pulses or held level.
module tb_gate_selftest_ctrl;
    import gate_pkg::*;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic       fv;
        logic [1:0] vec;
        logic [6:0] mask;
        int         lat;
    } exp_t;

    logic clk;
    logic rst0, rst1, rst2;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bit   busy_p [3];
    bit   done_p [3];
    int   st_cyc [3];

    // Fault injection: stuck-at-0, stuck-at-1 and inversion masks per instance
    logic [6:0] s0 [3];
    logic [6:0] s1 [3];
    logic [6:0] inv [3];
    logic [6:0] gold0, gold1, gold2;

    gate_selftest_ctrl_if #(.CNT_W(8)) if0 ();
    gate_selftest_ctrl_if #(.CNT_W(8)) if1 ();
    gate_selftest_ctrl_if #(.CNT_W(2)) if2 ();

    gate_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) u0 (.clk(clk), .rst(rst0), .bus(if0));
    gate_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(3), .CNT_W(8)) u1 (.clk(clk), .rst(rst1), .bus(if1));
    gate_selftest_ctrl #(.SETTLE_CYCLES(0), .PASSES(2), .CNT_W(2)) u2 (.clk(clk), .rst(rst2), .bus(if2));

    gate_golden g0 (.a(if0.op_a), .b(if0.op_b), .res(gold0));
    gate_golden g1 (.a(if1.op_a), .b(if1.op_b), .res(gold1));
    gate_golden g2 (.a(if2.op_a), .b(if2.op_b), .res(gold2));

    assign if0.gate_res = ((gold0 & ~s0[0]) | s1[0]) ^ inv[0];
    assign if1.gate_res = ((gold1 & ~s0[1]) | s1[1]) ^ inv[1];
    assign if2.gate_res = ((gold2 & ~s0[2]) | s1[2]) ^ inv[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, id, act, exp_v);
        end
    endtask

    // Monitor step: timestamps busy rising, pops and compares on done rising
    task automatic mon_step(input int id, input logic busy, input logic done, input logic pass,
                            input logic [7:0] err, input logic fv, input logic [1:0] vec,
                            input logic [6:0] mask);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (busy === 1'b1 && !busy_p[id]) st_cyc[id] = cyc;
        if (done === 1'b1 && !done_p[id]) begin
            case (id)
                0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done inst%0d: got done=1, expected no run result", id);
            end else begin
                chk("pass",         id, 32'(pass), 32'(e.pass));
                chk("err_cnt",      id, 32'(err),  32'(e.err));
                chk("fail_valid",   id, 32'(fv),   32'(e.fv));
                chk("fail_vec",     id, 32'(vec),  32'(e.vec));
                chk("fail_mask",    id, 32'(mask), 32'(e.mask));
                chk("latency",      id, 32'(cyc - st_cyc[id]), 32'(e.lat));
                chk("busy_at_done", id, 32'(busy), 32'd0);
            end
        end
        busy_p[id] = (busy === 1'b1);
        done_p[id] = (done === 1'b1);
    endtask

    always @(negedge clk) begin
        mon_step(0, if0.busy, if0.done, if0.pass, if0.err_cnt, if0.fail_valid, if0.fail_vec, if0.fail_mask);
        mon_step(1, if1.busy, if1.done, if1.pass, if1.err_cnt, if1.fail_valid, if1.fail_vec, if1.fail_mask);
        mon_step(2, if2.busy, if2.done, if2.pass, 8'(if2.err_cnt), if2.fail_valid, if2.fail_vec, if2.fail_mask);
    end

    function automatic logic done_of(input int id);
        case (id)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       if0.start = v;
            1:       if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    // Returns on the negedge just after the accepting edge
    task automatic pulse(input int id);
        @(negedge clk);
        set_start(id, 1'b1);
        @(negedge clk);
        set_start(id, 1'b0);
    endtask

    task automatic wait_done(input int id, input int budget);
        int n;
        n = 0;
        while (done_of(id) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", id, 32'(done_of(id)), 32'd1);
    endtask

    function automatic exp_t mk(input logic p, input logic [7:0] err, input logic fv,
                                input logic [1:0] vec, input logic [6:0] mask, input int lat);
        exp_t e;
        e.pass = p; e.err = err; e.fv = fv; e.vec = vec; e.mask = mask; e.lat = lat;
        return e;
    endfunction

    initial begin
        int n;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s0[i] = '0; s1[i] = '0; inv[i] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  0, 32'(if0.busy), 32'd0);
        chk("rst_done",  0, 32'(if0.done), 32'd0);
        chk("rst_pass",  0, 32'(if0.pass), 32'd0);
        chk("rst_err",   0, 32'(if0.err_cnt), 32'd0);
        chk("rst_fv",    0, 32'(if0.fail_valid), 32'd0);
        chk("rst_fvec",  0, 32'(if0.fail_vec), 32'd0);
        chk("rst_fmask", 0, 32'(if0.fail_mask), 32'd0);
        chk("rst_ops",   0, 32'({if0.op_a, if0.op_b}), 32'd0);
        chk("rst_busy",  1, 32'(if1.busy), 32'd0);
        chk("rst_done",  2, 32'(if2.done), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // Fault-free sweep, operand order 00,01,10,11
        q0.push_back(mk(1'b1, 8'd0, 1'b0, 2'b00, 7'h00, 16));
        pulse(0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("op_order", 0, 32'({if0.op_a, if0.op_b}), 32'(k));
            repeat (4) @(negedge clk);
        end
        wait_done(0, 40);
        chk("ops_hold_after_done", 0, 32'({if0.op_a, if0.op_b}), 32'd3);

        // XOR stuck-at-0: vectors 01 and 10 fail
        s0[0] = 7'b0100000;
        q0.push_back(mk(1'b0, 8'd2, 1'b1, 2'b01, 7'b0100000, 16));
        pulse(0);
        wait_done(0, 40);

        // Reset during SETTLE of vector 10 aborts the run
        pulse(0);
        repeat (9) @(negedge clk);
        chk("pre_abort_ops", 0, 32'({if0.op_a, if0.op_b}), 32'd2);
        chk("pre_abort_err", 0, 32'(if0.err_cnt), 32'd1);
        rst0 = 1'b1;
        @(negedge clk);
        chk("abort_busy", 0, 32'(if0.busy), 32'd0);
        chk("abort_done", 0, 32'(if0.done), 32'd0);
        chk("abort_err",  0, 32'(if0.err_cnt), 32'd0);
        chk("abort_ops",  0, 32'({if0.op_a, if0.op_b}), 32'd0);
        chk("abort_fv",   0, 32'(if0.fail_valid), 32'd0);
        rst0 = 1'b0;
        s0[0] = '0;
        q0.push_back(mk(1'b1, 8'd0, 1'b0, 2'b00, 7'h00, 16));
        pulse(0);
        wait_done(0, 40);

        // start held through the whole run yields exactly one run
        s0[0] = 7'b0100000;
        q0.push_back(mk(1'b0, 8'd2, 1'b1, 2'b01, 7'b0100000, 16));
        @(negedge clk);
        if0.start = 1'b1;
        n = 0;
        @(negedge clk);
        while (if0.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if0.start = 1'b0;
        chk("held_start_done", 0, 32'(if0.done), 32'd1);
        repeat (3) @(negedge clk);
        chk("held_start_one_run", 0, 32'(if0.busy), 32'd0);

        // Restart from done clears previous results
        s0[0] = '0;
        q0.push_back(mk(1'b1, 8'd0, 1'b0, 2'b00, 7'h00, 16));
        pulse(0);
        chk("restart_done_clr", 0, 32'(if0.done), 32'd0);
        chk("restart_err_clr",  0, 32'(if0.err_cnt), 32'd0);
        chk("restart_pass_clr", 0, 32'(if0.pass), 32'd0);
        chk("restart_fv_clr",   0, 32'(if0.fail_valid), 32'd0);
        chk("restart_busy",     0, 32'(if0.busy), 32'd1);
        wait_done(0, 40);

        // NOR stuck-at-1 over three passes: 01,10,11 fail each pass
        s1[1] = 7'b0010000;
        q1.push_back(mk(1'b0, 8'd9, 1'b1, 2'b01, 7'b0010000, 48));
        pulse(1);
        wait_done(1, 100);

        // All outputs inverted, no settle window, 2-bit saturating counter
        inv[2] = 7'h7F;
        q2.push_back(mk(1'b0, 8'd3, 1'b1, 2'b00, 7'h7F, 16));
        pulse(2);
        wait_done(2, 60);

        repeat (2) @(negedge clk);
        chk("q0_drained", 0, 32'(q0.size()), 32'd0);
        chk("q1_drained", 1, 32'(q1.size()), 32'd0);
        chk("q2_drained", 2, 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
